// File: rtl/ps2_key_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_key_pkg
//  Description : Shared scan-code constants, decoder state encoding and a
//                small classification helper for the PS/2 key decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
package ps2_key_pkg;

  localparam logic [7:0] SC_BREAK = 8'hF0;  // break (key-up) prefix
  localparam logic [7:0] SC_EXT   = 8'hE0;  // extended-code prefix
  localparam logic [7:0] SC_BAT   = 8'hAA;  // keyboard self-test passed
  localparam logic [7:0] SC_ERR0  = 8'h00;  // keyboard buffer overrun / error
  localparam logic [7:0] SC_ERR1  = 8'hFF;  // keyboard buffer overrun / error

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BRK     = 2'd1,
    ST_EXT     = 2'd2,
    ST_EXT_BRK = 2'd3
  } state_e;

  // Overrun/error bytes abort any pending prefix and are otherwise ignored.
  function automatic logic is_err_code(input logic [7:0] b);
    return (b == SC_ERR0) || (b == SC_ERR1);
  endfunction

endpackage : ps2_key_pkg
`default_nettype wire

// File: rtl/ps2_key_slot.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_key_slot
//  Description : Per-key held/press/release tracker. One instance per decoded
//                key; all outputs registered.
//  Ports       : clk_i       - system clock
//                rst_ni      - asynchronous active-low reset
//                match_i     - current byte matches this key (incl. ext flag)
//                make_i      - current byte is a make code
//                break_i     - current byte is a break code
//                bat_i       - keyboard self-test byte: force release
//                held_n_o    - 0 while key is held
//                press_o     - one-cycle pulse on first make
//                release_o   - one-cycle pulse on release of a held key
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_key_slot (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic match_i,
  input  logic make_i,
  input  logic break_i,
  input  logic bat_i,
  output logic held_n_o,
  output logic press_o,
  output logic release_o
);

  logic held_n_q, held_n_d;
  logic press_q, press_d;
  logic release_q, release_d;

  always_comb begin
    held_n_d  = held_n_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    if (bat_i) begin
      // Keyboard restarted: whatever was held is now up.
      if (!held_n_q) begin
        held_n_d  = 1'b1;
        release_d = 1'b1;
      end
    end else if (match_i && make_i) begin
      // Typematic repeats arrive while already held and are swallowed here.
      if (held_n_q) begin
        held_n_d = 1'b0;
        press_d  = 1'b1;
      end
    end else if (match_i && break_i) begin
      if (!held_n_q) begin
        held_n_d  = 1'b1;
        release_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      held_n_q  <= 1'b1;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      held_n_q  <= held_n_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign held_n_o  = held_n_q;
  assign press_o   = press_q;
  assign release_o = release_q;

endmodule : ps2_key_slot
`default_nettype wire

// File: rtl/ps2_key_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_key_decoder
//  Description : PS/2 scan-code decoder for NUM_KEYS configurable keys. Parses
//                F0/E0 prefixes, suppresses typematic repeats, drops a stale
//                prefix after TIMEOUT_CYCLES and recovers on keyboard BAT (AA).
//  Options     : define KEYDEC_EXTENDED_EN to decode E0-prefixed keys selected
//                by KEY_EXT; otherwise the byte after E0 is discarded.
//  Ports       : CLOCK_50       - system clock
//                resetn         - asynchronous active-low reset
//                rx_data        - byte from PS2_Controller
//                rx_valid       - one-cycle strobe qualifying rx_data
//                key_held_n     - per key, 0 while held
//                key_press      - per key, one-cycle pulse on first make
//                key_release    - per key, one-cycle pulse on break of held key
//                kbd_reset_seen - one-cycle pulse on 0xAA
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_key_decoder #(
  parameter int                      NUM_KEYS       = 4,
  parameter logic [NUM_KEYS*8-1:0]   KEY_CODES      = {8'h2B, 8'h23, 8'h1B, 8'h1C},
  parameter logic [NUM_KEYS-1:0]     KEY_EXT        = '0,
  parameter int                      TIMEOUT_CYCLES = 2500000
) (
  input  logic                CLOCK_50,
  input  logic                resetn,
  input  logic [7:0]          rx_data,
  input  logic                rx_valid,
  output logic [NUM_KEYS-1:0] key_held_n,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic                kbd_reset_seen
);

  import ps2_key_pkg::*;

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] c_CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

`ifdef KEYDEC_EXTENDED_EN
  localparam logic c_EXT_EN = 1'b1;
`else
  localparam logic c_EXT_EN = 1'b0;
`endif

  // With extended decoding off every key is treated as a plain key; the
  // extended path never issues make/break strobes, so no aliasing occurs.
  localparam logic [NUM_KEYS-1:0] c_KEY_EXT_EFF = KEY_EXT & {NUM_KEYS{c_EXT_EN}};

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bat_seen_q;

  logic             w_make;
  logic             w_break;
  logic             w_ext_sel;
  logic             w_bat;
  logic [NUM_KEYS-1:0] w_match;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    w_make    = 1'b0;
    w_break   = 1'b0;
    w_ext_sel = 1'b0;
    w_bat     = 1'b0;
    if (rx_valid) begin
      // A byte always beats the timeout, even on the expiry cycle.
      cnt_d = '0;
      if (rx_data == SC_BAT) begin
        w_bat   = 1'b1;
        state_d = ST_IDLE;
      end else if (is_err_code(rx_data)) begin
        state_d = ST_IDLE;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            if (rx_data == SC_BREAK)    state_d = ST_BRK;
            else if (rx_data == SC_EXT) state_d = ST_EXT;
            else                        w_make  = 1'b1;
          end
          ST_BRK: begin
            w_break = 1'b1;
            state_d = ST_IDLE;
          end
          ST_EXT: begin
            if (rx_data == SC_BREAK) begin
              state_d = ST_EXT_BRK;
            end else begin
              w_make    = c_EXT_EN;
              w_ext_sel = 1'b1;
              state_d   = ST_IDLE;
            end
          end
          ST_EXT_BRK: begin
            w_break   = c_EXT_EN;
            w_ext_sel = 1'b1;
            state_d   = ST_IDLE;
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end else if (state_q != ST_IDLE) begin
      // Counter holds at its maximum; the state falls back to IDLE there.
      if (cnt_q == c_CNT_MAX) state_d = ST_IDLE;
      else                    cnt_d   = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      bat_seen_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bat_seen_q <= w_bat;
    end
  end

  assign kbd_reset_seen = bat_seen_q;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_slot
    assign w_match[i] = (KEY_CODES[8*i +: 8] == rx_data) &&
                        (c_KEY_EXT_EFF[i] == w_ext_sel);

    ps2_key_slot u_slot (
      .clk_i     (CLOCK_50),
      .rst_ni    (resetn),
      .match_i   (w_match[i]),
      .make_i    (w_make),
      .break_i   (w_break),
      .bat_i     (w_bat),
      .held_n_o  (key_held_n[i]),
      .press_o   (key_press[i]),
      .release_o (key_release[i])
    );
  end

endmodule : ps2_key_decoder
`default_nettype wire

// File: doc/ps2_key_decoder.md
Name: ps2_key_decoder

Overview:
- Parametrised scan-code decoder between PS2_Controller (received_data / received_data_en) and game logic.
- Tracks make/break codes for NUM_KEYS configurable keys and outputs an active-low held level per key, plus one-cycle press and release pulses.
- Adds the following to the fixed 4-key decoder: break-prefix parsing per byte, typematic-repeat suppression, independent simultaneous keys, prefix timeout, and keyboard self-test recovery.

Parameters:
- NUM_KEYS, 4, number of decoded keys (1..16).
- KEY_CODES, {8'h2B,8'h23,8'h1B,8'h1C}, packed NUM_KEYS×8 make codes. Key i is bits [8i+7:8i]. The default maps key0=A, key1=S, key2=D, key3=F.
- KEY_EXT, 4'b0000, per-key flag; 1 means the key is an E0-prefixed code. Used only with KEYDEC_EXTENDED_EN.
- TIMEOUT_CYCLES, 2500000, maximum cycles from a prefix byte to its following byte (50 ms at 50 MHz).

Ports:
- CLOCK_50, input, 1, system clock.
- resetn, input, 1, asynchronous active-low reset.
- rx_data, input, 8, byte from PS2_Controller.
- rx_valid, input, 1, one-cycle strobe qualifying rx_data.
- key_held_n, output, NUM_KEYS, 0 while key i is held.
- key_press, output, NUM_KEYS, one-cycle pulse on the first make of key i.
- key_release, output, NUM_KEYS, one-cycle pulse on the break of a held key i.
- kbd_reset_seen, output, 1, one-cycle pulse when 0xAA (BAT pass) is received.

Behaviour:
- Reset (asynchronous, resetn=0): key_held_n=all 1s, key_press=0, key_release=0, kbd_reset_seen=0, state=IDLE, timeout counter=0. Reset mid-sequence discards any pending prefix.
- All outputs are registered. A byte with rx_valid high in cycle N affects outputs in cycle N+1. Pulses last exactly one cycle.
- State machine:
  - IDLE: F0 → BRK. E0 → EXT. Any other byte is treated as a make code.
  - BRK: the next byte is treated as a break code → IDLE.
  - EXT: F0 → EXT_BRK. Any other byte is treated as an extended make code → IDLE.
  - EXT_BRK: the next byte is treated as an extended break code → IDLE.
- Make of code c:
  - For every i with KEY_CODES[i]==c and a matching extended flag: if held_n[i]=1, clear held_n[i] and pulse press[i].
  - If held_n[i] is already 0 (typematic repeat), no pulse.
- Break of code c:
  - For every matching i with held_n[i]=0: set held_n[i]=1 and pulse release[i].
  - A break for a key not held produces no pulse.
- Duplicate entries in KEY_CODES all update together. Unmatched codes are ignored silently.
- Different keys pressed in different bytes remain held independently. A press pulse on one key never alters another key's state.
- Special bytes:
  - 0xAA in any state: pulse kbd_reset_seen; every held key gets a release pulse and held_n=1; state → IDLE.
  - 0x00 or 0xFF (overrun/error) in any state: ignored; state → IDLE.
- Timeout:
  - The counter clears on every rx_valid and increments while state≠IDLE.
  - When the count reaches TIMEOUT_CYCLES-1, state → IDLE and the prefix is dropped.
  - If rx_valid coincides with the timeout cycle, rx_valid wins and the byte is processed in the current state.
  - The counter saturates and does not wrap. Counter width is $clog2(TIMEOUT_CYCLES).
- rx_valid held high for several cycles is treated as several bytes. This is legal but not produced by PS2_Controller.

Optional Feature:
- Macro KEYDEC_EXTENDED_EN.
- Defined:
  - EXT and EXT_BRK match only keys with KEY_EXT[i]=1.
  - IDLE and BRK match only keys with KEY_EXT[i]=0.
- Undefined:
  - KEY_EXT is ignored.
  - E0 still enters EXT/EXT_BRK, but the byte that follows is discarded. Extended keys therefore never alias normal keys.

Decomposition:
- Package ps2_key_pkg:
  - Scan-code constants SC_BREAK=8'hF0, SC_EXT=8'hE0, SC_BAT=8'hAA, SC_ERR0=8'h00, SC_ERR1=8'hFF.
  - 2-bit state encoding: IDLE, BRK, EXT, EXT_BRK.
- Sub-module ps2_key_slot, generated NUM_KEYS times:
  - Inputs: code match, make/break strobe, BAT clear.
  - Holds held_n.
  - Generates the press and release pulses.

Test Plan:
- Bytes 1C, F0 1C → key_press[0] pulses at 1C+1 cycle; key_held_n=4'b1110 until the break; then key_release[0] pulses and key_held_n=4'b1111.
- Bytes 1C 1C 1C (typematic) → exactly one key_press[0] pulse; held_n[0] stays 0.
- Bytes 1C, 2B, F0 1C → keys 0 and 3 both held (4'b0110); after the break, key_held_n=4'b0111 and only release[0] pulses.
- Byte F0 then no byte for TIMEOUT_CYCLES (set 100 in the bench), then 1B → state returns to IDLE at cycle 99; 1B is treated as a make, so press[1] pulses.
- Keys 0 and 2 held, then byte AA → kbd_reset_seen pulses; release[0] and release[2] pulse in the same cycle; key_held_n=4'b1111. Also: resetn low mid-F0 → all outputs return to their reset values at once.
- With KEYDEC_EXTENDED_EN, KEY_EXT=4'b1000, KEY_CODES[3]=6B: bytes 6B → no press; bytes E0 6B → press[3]. Without the macro: bytes E0 1C → no press[0].
